fetch_stage: RTL and testbench

//  Instruction fetch stage feeding the decode stage and the three-ported register file.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_skid_buf.sv | 36 +++
 rtl/fetch_stage.sv | 165 ++++++++++++++++
 tb/tb_fetch_stage.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam int R15_OFFSET_STEPS = 2;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer for a word that returns while decode is stalled.
module fetch_skid_buf #(
  parameter int WIDTH       = 16,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic                   unload,
  input  logic                   flush,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic [WIDTH-1:0]       in_pc,
  output logic                   full,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [WIDTH-1:0]       pc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= 1'b0;
    end else if (flush || unload) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end
  end

  // Payload is only meaningful while full, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      instr <= in_instr;
      pc    <= in_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, decode skid and branch flush.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               INSTR_WIDTH = 32,
  parameter int               PC_STEP     = 4,
  parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   imem_req,
  output logic [WIDTH-1:0]       imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [WIDTH-1:0]       branch_target,
  output logic                   if_valid,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0]       if_pc,
  output logic [WIDTH-1:0]       r15,
  output logic [15:0]            perf_fetched,
  output logic [15:0]            perf_stalls
);

  localparam logic [WIDTH-1:0] STEP       = WIDTH'(PC_STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(PC_STEP - 1));
  localparam logic [WIDTH-1:0] R15_OFFSET = WIDTH'(PC_STEP * R15_OFFSET_STEPS);

  fetch_state_t           state;
  logic [WIDTH-1:0]       pc;
  logic [WIDTH-1:0]       fetch_pc;
  logic                   discard;
  logic                   skid_full;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic [WIDTH-1:0]       skid_pc;
  logic                   rsp_live;
  logic                   take_direct;
  logic                   to_skid;
  logic                   from_skid;
  logic                   load_out;

  // Request is masked while reset is held so memory never sees a fetch from a resetting stage.
  assign imem_req  = reset_n && (state == S_REQ);
  assign imem_addr = pc;

  assign rsp_live    = (state == S_WAIT) && imem_rvalid && !discard && !branch_taken;
  assign take_direct = rsp_live && (!if_valid || !stall);
  assign to_skid     = rsp_live && if_valid && stall;
  assign from_skid   = (state == S_HOLD) && skid_full && !stall && !branch_taken;
  assign load_out    = take_direct || from_skid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      discard <= 1'b0;
    end else if (branch_taken) begin
      pc <= branch_target & ALIGN_MASK;
      case (state)
        S_REQ: begin
          if (imem_gnt) begin
            state   <= S_WAIT;
            discard <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state   <= S_REQ;
            discard <= 1'b0;
          end else begin
            discard <= 1'b1;
          end
        end
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (imem_gnt) begin
            pc    <= pc + STEP;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            discard <= 1'b0;
            state   <= (discard || !if_valid || !stall) ? S_REQ : S_HOLD;
          end
        end
        default: begin
          if (!stall) state <= S_REQ;
        end
      endcase
    end
  end

  // Address of the outstanding request; always written at grant before it is used.
  always_ff @(posedge clk) begin
    if ((state == S_REQ) && imem_gnt) fetch_pc <= pc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= RESET_PC;
    end else if (branch_taken) begin
      if_valid <= 1'b0;
    end else if (load_out) begin
      if_valid <= 1'b1;
      if_instr <= from_skid ? skid_instr : imem_rdata;
      if_pc    <= from_skid ? skid_pc : fetch_pc;
    end else if (!stall) begin
      if_valid <= 1'b0;
    end
  end

  fetch_skid_buf #(
    .WIDTH       (WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (to_skid),
    .unload   (from_skid),
    .flush    (branch_taken),
    .in_instr (imem_rdata),
    .in_pc    (fetch_pc),
    .full     (skid_full),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  assign r15 = if_pc + R15_OFFSET;

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] fetched_q;
  logic [15:0] stalls_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetched_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (load_out)          fetched_q <= sat_inc16(fetched_q);
      if (stall && if_valid) stalls_q  <= sat_inc16(stalls_q);
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stalls  = stalls_q;
`else
  assign perf_fetched = '0;
  assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a reactive memory and a queue-based delivery model.
module tb_fetch_stage;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] r15;
  logic [15:0] perf_fetched;
  logic [15:0] perf_stalls;

  always #5 clk = ~clk;

  fetch_stage #(
    .WIDTH       (16),
    .INSTR_WIDTH (32),
    .PC_STEP     (4),
    .RESET_PC    (16'h0000)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .r15           (r15),
    .perf_fetched  (perf_fetched),
    .perf_stalls   (perf_stalls)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  // Memory: grants a pending request at the negedge, returns data rv_lat cycles after the grant cycle.
  int          rv_lat = 0;
  bit          gnt_en = 1'b1;
  bit          pend   = 1'b0;
  int          pend_cnt;
  logic [15:0] pend_addr;

  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pend        = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      imem_gnt = imem_req && !pend && gnt_en;
      if (imem_gnt) begin
        pend      = 1'b1;
        pend_cnt  = rv_lat;
        pend_addr = imem_addr;
      end
    end
  end

  // Model: live words queue (front = word decode should see), in-flight grants, next fetch address.
  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
  } word_t;

  word_t       q[$];
  logic [15:0] fl_addr[$];
  bit          fl_live[$];
  logic [15:0] exp_fetch = 16'h0000;
  int          m_fetched = 0;
  int          m_stalls  = 0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        q.delete();
        fl_addr.delete();
        fl_live.delete();
        exp_fetch = 16'h0000;
        m_fetched = 0;
        m_stalls  = 0;
      end else begin
        logic [15:0] r15_exp;
        bit          was_empty;
        bit          popped;
        r15_exp = if_pc + 16'd8;
        check("m_if_valid", if_valid, q.size() != 0);
        if (q.size() != 0) begin
          check("m_if_pc", if_pc, q[0].pc);
          check("m_if_instr", if_instr, q[0].instr);
        end
        check("m_r15", r15, r15_exp);
        check("m_req_outstanding", imem_req && (fl_addr.size() != 0 || q.size() > 1), 0);
        if (imem_req) check("m_imem_addr", imem_addr, exp_fetch);
        check("m_perf_fetched", perf_fetched, PERF ? m_fetched : 0);
        check("m_perf_stalls", perf_stalls, PERF ? m_stalls : 0);

        was_empty = (q.size() == 0);
        popped    = 1'b0;
        if (!branch_taken && !was_empty && !stall) begin
          void'(q.pop_front());
          popped = 1'b1;
        end
        if (imem_rvalid && fl_addr.size() != 0) begin
          logic [15:0] a;
          bit          live;
          a    = fl_addr.pop_front();
          live = fl_live.pop_front();
          if (live && !branch_taken) q.push_back('{pc: a, instr: mem_word(a)});
        end
        if (imem_req && imem_gnt) begin
          fl_addr.push_back(exp_fetch);
          fl_live.push_back(!branch_taken);
          exp_fetch = exp_fetch + 16'd4;
        end
        if (branch_taken) begin
          q.delete();
          foreach (fl_live[i]) fl_live[i] = 1'b0;
          exp_fetch = branch_target & 16'hFFFC;
        end
        if (q.size() != 0 && (popped || was_empty) && m_fetched < 65535) m_fetched++;
        if (stall && !was_empty && m_stalls < 65535) m_stalls++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm, input logic [15:0] exp_pc);
    int n;
    n = 0;
    while (!if_valid && n < 20) begin
      step();
      n++;
    end
    check({nm, "_vld"}, if_valid, 1);
    check(nm, if_pc, exp_pc);
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    check({nm, "_req"}, imem_req, 1);
  endtask

  int          exp_v[7]  = '{0, 0, 1, 0, 1, 0, 1};
  logic [15:0] exp_pc[7] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h4, 16'h0, 16'h8};

  initial begin
    reset_n       = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    repeat (3) step();
    check("rst_if_valid", if_valid, 0);
    check("rst_if_pc", if_pc, 16'h0000);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_r15", r15, 16'h0008);
    check("rst_imem_req", imem_req, 0);
    check("rst_perf_fetched", perf_fetched, 0);
    reset_n = 1'b1;

    // Zero-wait stream, then a 5-cycle stall that catches a returning word in the skid.
    for (int c = 0; c <= 6; c++) begin
      step();
      check("seq_valid", if_valid, exp_v[c]);
      if (exp_v[c] != 0) check("seq_pc", if_pc, exp_pc[c]);
      if (c == 0) begin
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 16'h0000);
      end
      if (c == 2) check("r15_at_pc0", r15, 16'h0008);
    end
    check("perf_fetched_3", perf_fetched, PERF ? 3 : 0);
    stall = 1'b1;
    for (int c = 7; c <= 10; c++) begin
      step();
      check("stall_hold_valid", if_valid, 1);
      check("stall_hold_pc", if_pc, 16'h0008);
    end
    check("perf_stalls_4", perf_stalls, PERF ? 4 : 0);
    check("perf_fetched_still_3", perf_fetched, PERF ? 3 : 0);
    step();
    stall = 1'b0;
    check("release_pc", if_pc, 16'h0008);
    step();
    check("skid_out_valid", if_valid, 1);
    check("skid_out_pc", if_pc, 16'h000C);
    check("skid_out_instr", if_instr, 32'h5A56FFF3);
    step();
    check("after_skid_gap", if_valid, 0);
    step();
    check("after_skid_pc", if_pc, 16'h0010);

    // Branch while waiting: returning word is dropped and fetch restarts at aligned target.
    rv_lat = 1;
    step();
    wait_req("br_wait");
    step();
    branch_taken  = 1'b1;
    branch_target = 16'h0102;
    step();
    branch_taken = 1'b0;
    check("br_drop_valid", if_valid, 0);
    step();
    check("br_req", imem_req, 1);
    check("br_addr", imem_addr, 16'h0100);
    rv_lat = 0;
    step();
    check("br_gap1", if_valid, 0);
    step();
    check("br_gap2", if_valid, 0);
    step();
    check("br_tgt_valid", if_valid, 1);
    check("br_tgt_pc", if_pc, 16'h0100);
    check("br_tgt_instr", if_instr, 32'h5B5AFEFF);

    // Branch, rvalid and stall together: nothing reaches the skid, next request to the target.
    stall = 1'b1;
    step();
    check("combo_pre_pc", if_pc, 16'h0100);
    check("combo_pre_rvalid", imem_rvalid, 1);
    branch_taken  = 1'b1;
    branch_target = 16'h0200;
    step();
    branch_taken = 1'b0;
    stall        = 1'b0;
    check("combo_valid", if_valid, 0);
    check("combo_req", imem_req, 1);
    check("combo_addr", imem_addr, 16'h0200);
    wait_valid("combo_first", 16'h0200);
    step();
    wait_valid("combo_second", 16'h0204);

    // Wrap: redirect to 0xFFFC while the request is held off.
    gnt_en = 1'b0;
    step();
    step();
    check("wrap_held_req", imem_req && !imem_gnt, 1);
    branch_taken  = 1'b1;
    branch_target = 16'hFFFE;
    step();
    branch_taken = 1'b0;
    check("wrap_addr", imem_addr, 16'hFFFC);
    gnt_en = 1'b1;
    wait_valid("wrap_pc", 16'hFFFC);
    check("wrap_r15", r15, 16'h0004);
    check("wrap_instr", if_instr, 32'hA5A60003);
    wait_req("wrap_next");
    check("wrap_next_addr", imem_addr, 16'h0000);

    // Reset in the middle of a wait; the late response must be ignored.
    rv_lat = 3;
    step();
    wait_req("rst_mid");
    step();
    reset_n = 1'b0;
    #1;
    check("rst_mid_valid", if_valid, 0);
    check("rst_mid_pc", if_pc, 16'h0000);
    check("rst_mid_instr", if_instr, 32'h0);
    check("rst_mid_r15", r15, 16'h0008);
    check("rst_mid_req", imem_req, 0);
    check("rst_mid_perf", perf_fetched, 0);
    step();
    reset_n = 1'b1;
    rv_lat  = 0;
    step();
    check("rst_rel_req", imem_req, 1);
    check("rst_rel_addr", imem_addr, 16'h0000);
    step();
    step();
    check("rst_stale_ignored", if_valid, 0);
    wait_valid("rst_first", 16'h0000);
    check("rst_first_instr", if_instr, 32'h5A5AFFFF);

    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
